// File: rtl/write_image.sv
// write_image: captures one frame of pixel words from a valid/ready stream
// into a frame buffer, one write per accepted word, with abort and a
// single-cycle completion pulse.
module write_image #(
  parameter int DATA_W = 16,
  parameter int SIZE   = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index of the final word and the saturation ceiling for count.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(SIZE - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(SIZE);

  state_t state;
  logic   xfer;

  // Ready only while capturing; abort takes effect in the same cycle so no
  // word is accepted on the cycle the frame is cancelled.
  assign pix_ready = (state == WRITE) && !abort;
  assign xfer      = pix_valid && pix_ready;

  // Frame FSM with registered status outputs and the frame-buffer write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= xfer;
      // Address is the word's index in the frame, which is the count before
      // this transfer increments it.
      if (xfer) begin
        mem_addr  <= count[ADDR_W-1:0];
        mem_wdata <= pix_data;
      end
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= WRITE;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pix_valid) begin
            if (count < FULL_CNT) begin
              count <= count + 1'b1;
            end
            if (count == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_image.sv
// tb_write_image: randomized stimulus against a frame-level reference model;
// expected writes go through a scoreboard queue checked by a separate monitor.
module tb_write_image;

  localparam int DATA_W = 16;
  localparam int SIZE   = 4;
  localparam int ADDR_W = 3;
  localparam int CYCLES = 3000;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;

  write_image #(.DATA_W(DATA_W), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    bit          last;
  } wr_t;

  wr_t         sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model: is a frame open, is its final write in flight, and how
  // many words of the current/most recent frame have been taken.
  bit          frame_open = 0;
  bit          finishing  = 0;
  int unsigned words      = 0;

  // Last write seen by the monitor, which the buffer port must hold.
  int unsigned last_addr  = 0;
  int unsigned last_data  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs to the model; returns nothing, pushes writes.
  task automatic model_step(input bit s, input bit a, input bit v, input int unsigned d);
    wr_t w;
    if (finishing) begin
      finishing = 0;
    end else if (!frame_open) begin
      if (s && !a) begin
        frame_open = 1;
        words      = 0;
      end
    end else if (a) begin
      frame_open = 0;
    end else if (v) begin
      w.addr = words;
      w.data = d;
      w.last = (words == SIZE - 1);
      sb.push_back(w);
      words++;
      if (words == SIZE) begin
        frame_open = 0;
        finishing  = 1;
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_count",     32'(count),     32'd0);
  endtask

  // Monitor: pops one expected write for every cycle the DUT writes.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_we) begin
          if (sb.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
          end else begin
            w = sb.pop_front();
            chk("mem_addr",  32'(mem_addr),  w.addr);
            chk("mem_wdata", 32'(mem_wdata), w.data);
            chk("done_on_last", 32'(done), 32'(w.last));
            last_addr = w.addr;
            last_data = w.data;
          end
        end else begin
          chk("done_without_write", 32'(done), 32'd0);
          chk("addr_hold",  32'(mem_addr),  last_addr);
          chk("wdata_hold", 32'(mem_wdata), last_data);
        end
      end
    end
  end

  // Driver: random inputs per cycle, model update, and status checks.
  initial begin
    int mode;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    #3;
    check_reset_outputs();
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      mode = (cyc / 250) % 4;
      start    = ($urandom_range(0, 5) == 0);
      pix_data = DATA_W'($urandom);
      case (mode)
        0: begin
          pix_valid = 1'b1;
          abort     = ($urandom_range(0, 40) == 0);
        end
        1: begin
          pix_valid = $urandom_range(0, 1) == 1;
          abort     = ($urandom_range(0, 20) == 0);
        end
        2: begin
          start     = ($urandom_range(0, 1) == 1);
          pix_valid = $urandom_range(0, 3) != 0;
          abort     = ($urandom_range(0, 3) == 0);
        end
        default: begin
          pix_valid = (cyc % 3 == 0);
          abort     = ($urandom_range(0, 30) == 0);
        end
      endcase
      #1;
      chk("pix_ready", 32'(pix_ready), 32'(frame_open && !finishing && !abort));
      chk("busy",      32'(busy),      32'(frame_open || finishing));
      chk("count",     32'(count),     words);
      model_step(start, abort, pix_valid, 32'(pix_data));

      // Occasional asynchronous reset, placed away from both clock edges.
      if ($urandom_range(0, 149) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        frame_open = 0;
        finishing  = 0;
        words      = 0;
        last_addr  = 0;
        last_data  = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    start     = 1'b0;
    abort     = 1'b0;
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
